// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and constants for the write-back arbiter
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // One pending register-file write: destination plus data.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Which path owns the write port this cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LDQ,
        WB_LDBYP
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - execute/memory/decode/regfile signal bundle for wb_arbiter
//
// master: the core side (drives ALU results, load traffic and decode queries)
// slave : the arbiter (drives ld_ready, stall, RegWrite/waddr/wdata, busy)
interface wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);

    logic                      alu_we;
    logic [rf_pkg::REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]           alu_wdata;
    logic                      ld_issue;
    logic [rf_pkg::REG_AW-1:0] ld_rd;
    logic                      ld_valid;
    logic                      ld_ready;
    logic [rf_pkg::REG_AW-1:0] ld_rd_ret;
    logic [XLEN-1:0]           ld_data;
    logic [rf_pkg::REG_AW-1:0] raddr1;
    logic [rf_pkg::REG_AW-1:0] raddr2;
    logic                      dec_we;
    logic [rf_pkg::REG_AW-1:0] dec_rd;
    logic                      stall;
    logic                      RegWrite;
    logic [rf_pkg::REG_AW-1:0] waddr;
    logic [XLEN-1:0]           wdata;
    logic [NREG-1:0]           busy;

    modport master (
        output alu_we, alu_rd, alu_wdata,
        output ld_issue, ld_rd,
        output ld_valid, ld_rd_ret, ld_data,
        output raddr1, raddr2, dec_we, dec_rd,
        input  ld_ready, stall, RegWrite, waddr, wdata, busy
    );

    modport slave (
        input  alu_we, alu_rd, alu_wdata,
        input  ld_issue, ld_rd,
        input  ld_valid, ld_rd_ret, ld_data,
        input  raddr1, raddr2, dec_we, dec_rd,
        output ld_ready, stall, RegWrite, waddr, wdata, busy
    );

endinterface

// File: rtl/ldq_fifo.sv
// rtl/ldq_fifo.sv - circular buffer holding load returns that lost arbitration
//
// Ports: clk, reset (sync, active-high), push/din, pop, full, empty,
// head (entry at the read pointer), count (registered occupancy).
module ldq_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  wb_req_t                      din,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output wb_req_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter with load scoreboard
//
// Ports: Clk, Reset (sync, active-high), bus (wb_arbiter_if.slave):
// ALU result in, load issue/return handshake, decode hazard query (stall),
// registered RegWrite/waddr/wdata to the register file, busy scoreboard.
module wb_arbiter #(
    parameter int XLEN      = rf_pkg::XLEN,
    parameter int NREG      = 32,
    parameter int LDQ_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    wb_arbiter_if.slave bus
);

    localparam int CW = $clog2(LDQ_DEPTH + 1);

    rf_pkg::wb_src_e src;
    rf_pkg::wb_req_t ret_req;
    rf_pkg::wb_req_t head_req;
    rf_pkg::wb_req_t win_req;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic ld_acc;
    logic ret_live;
    logic alu_live;

    logic [NREG-1:0]           busy_q;
    logic [NREG-1:0]           busy_d;
    logic                      regwrite_q;
    logic [rf_pkg::REG_AW-1:0] waddr_q;
    logic [XLEN-1:0]           wdata_q;

    assign bus.ld_ready = !Reset && !fifo_full;
    assign ld_acc       = bus.ld_valid && bus.ld_ready;
    // Returns to x0 are consumed by the handshake but never become candidates.
    assign ret_live     = ld_acc && (bus.ld_rd_ret != '0);
    assign alu_live     = bus.alu_we && (bus.alu_rd != '0);
    assign ret_req      = '{rd: bus.ld_rd_ret, data: bus.ld_data};

    ldq_fifo #(
        .DEPTH (LDQ_DEPTH)
    ) u_ldq (
        .clk   (Clk),
        .reset (Reset),
        .push  (fifo_push),
        .din   (ret_req),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_req),
        .count (fifo_count)
    );

    // Fixed priority: ALU, then oldest buffered load, then a fresh return
    // straight through when nothing older is waiting.
    always_comb begin
        src       = rf_pkg::WB_NONE;
        win_req   = '0;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        if (alu_live) begin
            src     = rf_pkg::WB_ALU;
            win_req = '{rd: bus.alu_rd, data: bus.alu_wdata};
        end else if (!fifo_empty) begin
            src      = rf_pkg::WB_LDQ;
            win_req  = head_req;
            fifo_pop = 1'b1;
        end else if (ret_live && (fifo_count == '0)) begin
            src     = rf_pkg::WB_LDBYP;
            win_req = ret_req;
        end
        fifo_push = ret_live && (src != rf_pkg::WB_LDBYP);
    end

    // Clear on load write-back first, then set on issue so a newer load to
    // the same register keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if ((src == rf_pkg::WB_LDQ) || (src == rf_pkg::WB_LDBYP)) begin
            busy_d[win_req.rd] = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_rd != '0)) begin
            busy_d[bus.ld_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
        end else begin
            regwrite_q <= (src != rf_pkg::WB_NONE);
            if (src != rf_pkg::WB_NONE) begin
                waddr_q <= win_req.rd;
                wdata_q <= win_req.data;
            end
            busy_q <= busy_d;
        end
    end

    assign bus.RegWrite = regwrite_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.busy     = busy_q;
    assign bus.stall    = busy_q[bus.raddr1] | busy_q[bus.raddr2]
                        | (bus.dec_we & busy_q[bus.dec_rd]);

endmodule
